axi_arbiter_mtos_aw_ar: RTL and testbench
=========================================

// Module: axi_arbiter_mtos_aw_ar
// PURPOSE
//  Master-to-slave request arbiter, one instance per slave port of the AXI switch.
//  Grants one of NUM+1 masters on AW and one on AR, holding each grant until the slave accepts.
//  Records AW grant order in a FIFO and steers the W channel to match, one burst at a time.
//  Companion to the slave-to-master B/R arbiter; grants drive the switch muxes.
// PARAMETERS
//  NUM          2   highest master index; masters 0..NUM
//  WFIFO_DEPTH  4   AW-order FIFO entries; power of two, >=2
// PORTS
//  ARESETn     in   1              asynchronous reset, active-low
//  ACLK        in   1              clock
//  AWSELECT    in   [NUM:0]        master's AWADDR decodes to this slave
//  AWVALID     in   [NUM:0]        per-master AWVALID
//  AWREADY     in   1              slave AWREADY
//  AWGRANT     out  [NUM:0]        one-hot AW grant (all-zero: none)
//  WVALID      in   [NUM:0]        per-master WVALID
//  WLAST       in   [NUM:0]        per-master WLAST
//  WREADY      in   1              slave WREADY
//  WGRANT      out  [NUM:0]        one-hot W grant
//  ARSELECT    in   [NUM:0]        master's ARADDR decodes to this slave
//  ARVALID     in   [NUM:0]        per-master ARVALID
//  ARREADY     in   1              slave ARREADY
//  ARGRANT     out  [NUM:0]        one-hot AR grant
//  WFIFO_CNT   out  log2(DEPTH)+1  AW-order FIFO occupancy
// BEHAVIOUR
//  - Reset: stAW=stAR=RUN; FIFO empty; WGRANT=0; WFIFO_CNT=0; priority pointers=NUM (master 0 first).
//    AWGRANT/ARGRANT are combinational in RUN and follow requests during and after reset.
//  - AR FSM, RUN: ARGRANT=sel(ARSELECT&ARVALID).
//    If grant!=0 and ARREADY=0: latch grant, go WAIT.
//    If grant!=0 and ARREADY=1: handshake done, stay RUN.
//  - AR FSM, WAIT: ARGRANT=latched value, stable even if requests change.
//    On ARREADY & |(ARGRANT&ARVALID): go RUN.
//  - AW FSM: same two-state rules with the AW signals.
//    In RUN, AWGRANT is forced to 0 while the FIFO is full (WFIFO_CNT==WFIFO_DEPTH).
//    WAIT is entered only with space, so it is never blocked.
//  - AW handshake (|(AWGRANT&AWVALID) & AWREADY): push the granted index into the FIFO.
//    WGRANT for that burst appears on the next cycle at the earliest (1-cycle AW->W latency).
//  - W: WGRANT = empty ? 0 : onehot(head).
//    Pop on |(WGRANT&WVALID&WLAST) & WREADY.
//    Non-last beats do not pop. W data before its AW is accepted is not granted.
//  - Push and pop in the same cycle: count unchanged. This is legal at full because push is gated off.
//  - Each handshake updates that channel's pointer to the granted index.
//    AW and AR pointers are independent.
//  - Multiple outstanding bursts from one master are allowed; FIFO order equals AW order.
//  - Reset mid-burst: all state cleared at once; pending W bursts are dropped from the FIFO.
// CONFIGURATION
//  AXI_ARB_MTOS_RR_EN defined:
//    sel() is round-robin; search starts at pointer+1 modulo NUM+1.
//  Undefined:
//    sel() is fixed priority, index 0 highest; pointers unused (may be removed).
//    A continuously requesting low index starves higher indices.
// TESTING
//  - Single AR: NUM=2, ARSELECT=ARVALID=3'b010, ARREADY=1.
//    -> ARGRANT=3'b010 same cycle; FSM stays RUN.
//  - AR hold: ARVALID=3'b100, ARREADY=0 for 3 cycles, then 3'b001 also raised.
//    -> ARGRANT stays 3'b100 until ARREADY=1, then next grant is 3'b001.
//  - Round-robin (macro on): all three masters request AR every cycle, ARREADY=1.
//    -> grants 001,010,100,001.
//  - Same stimulus with macro off -> grants 001,001,001.
//  - W order: AW from m2, then m0 (both accepted), then W with 4 beats each, WREADY=1.
//    -> WGRANT=100 until m2 WLAST, then 001; WFIFO_CNT 2->1->0.
//  - FIFO full: 4 AWs accepted, no W traffic.
//    -> WFIFO_CNT=4, AWGRANT=0 despite AWVALID.
//    Then one WLAST handshake -> AWGRANT reasserts next cycle.
//  - Reset mid-operation: ARESETn low while in WAIT with FIFO at 2.
//    -> WGRANT=0, WFIFO_CNT=0, both FSMs RUN.

Source files
------------

// File: rtl/axi_arbiter_mtos_aw_ar.sv
// Per-slave AW/AR request arbiter; AW grant order is queued so the W channel follows AW order.
// Define AXI_ARB_MTOS_RR_EN for round-robin selection, otherwise fixed priority (master 0 highest).
module axi_arbiter_mtos_aw_ar #(
    parameter int NUM         = 2,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                          ARESETn,
    input  logic                          ACLK,
    input  logic [NUM:0]                  AWSELECT,
    input  logic [NUM:0]                  AWVALID,
    input  logic                          AWREADY,
    output logic [NUM:0]                  AWGRANT,
    input  logic [NUM:0]                  WVALID,
    input  logic [NUM:0]                  WLAST,
    input  logic                          WREADY,
    output logic [NUM:0]                  WGRANT,
    input  logic [NUM:0]                  ARSELECT,
    input  logic [NUM:0]                  ARVALID,
    input  logic                          ARREADY,
    output logic [NUM:0]                  ARGRANT,
    output logic [$clog2(WFIFO_DEPTH):0]  WFIFO_CNT
);

    localparam int NM = NUM + 1;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;

    function automatic logic [IW-1:0] enc_f(input logic [NUM:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i <= NUM; i++) begin
            idx = idx | (oh[i] ? IW'(i) : IW'(0));
        end
        return idx;
    endfunction

    function automatic logic [NUM:0] onehot_f(input logic [IW-1:0] idx);
        logic [NUM:0] oh;
        oh = '0;
        for (int i = 0; i <= NUM; i++) begin
            oh[i] = (idx == IW'(i));
        end
        return oh;
    endfunction

`ifdef AXI_ARB_MTOS_RR_EN
    // Two passes: indices above the last winner first, then wrap around to 0..pointer.
    function automatic logic [NUM:0] sel_f(input logic [NUM:0] req, input logic [IW-1:0] ptr);
        logic [NUM:0] gnt;
        logic         hit;
        gnt = '0;
        hit = 1'b0;
        for (int i = 0; i <= NUM; i++) begin
            if (!hit && req[i] && (IW'(i) > ptr)) begin
                gnt[i] = 1'b1;
                hit    = 1'b1;
            end
        end
        for (int i = 0; i <= NUM; i++) begin
            if (!hit && req[i]) begin
                gnt[i] = 1'b1;
                hit    = 1'b1;
            end
        end
        return gnt;
    endfunction
`else
    function automatic logic [NUM:0] sel_f(input logic [NUM:0] req);
        logic [NUM:0] gnt;
        logic         hit;
        gnt = '0;
        hit = 1'b0;
        for (int i = 0; i <= NUM; i++) begin
            if (!hit && req[i]) begin
                gnt[i] = 1'b1;
                hit    = 1'b1;
            end
        end
        return gnt;
    endfunction
`endif

    state_e         ar_state_r, ar_state_s, aw_state_r, aw_state_s;
    logic [NUM:0]   ar_req_s, ar_sel_s, ar_latch_r;
    logic [NUM:0]   aw_req_s, aw_sel_s, aw_latch_r;
    logic           ar_hs_s, aw_hs_s, w_pop_s, fifo_full_s, fifo_empty_s;
    logic [IW-1:0]  fifo_mem_r [WFIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  cnt_r;

    assign ar_req_s     = ARSELECT & ARVALID;
    assign aw_req_s     = AWSELECT & AWVALID;
    assign fifo_full_s  = (cnt_r == CW'(WFIFO_DEPTH));
    assign fifo_empty_s = (cnt_r == CW'(0));

`ifdef AXI_ARB_MTOS_RR_EN
    logic [IW-1:0]  ar_ptr_r, aw_ptr_r;

    assign ar_sel_s = sel_f(ar_req_s, ar_ptr_r);
    assign aw_sel_s = fifo_full_s ? '0 : sel_f(aw_req_s, aw_ptr_r);

    // Priority pointers track the last handshaken master per channel.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ar_ptr_r <= IW'(NUM);
            aw_ptr_r <= IW'(NUM);
        end else begin
            if (ar_hs_s) ar_ptr_r <= enc_f(ARGRANT);
            if (aw_hs_s) aw_ptr_r <= enc_f(AWGRANT);
        end
    end
`else
    assign ar_sel_s = sel_f(ar_req_s);
    assign aw_sel_s = fifo_full_s ? '0 : sel_f(aw_req_s);
`endif

    assign ar_hs_s = ARREADY & (|(ARGRANT & ARVALID));
    assign aw_hs_s = AWREADY & (|(AWGRANT & AWVALID));

    // AR grant: live selection in RUN, frozen in WAIT until the slave accepts.
    always_comb begin
        ar_state_s = ar_state_r;
        ARGRANT    = '0;
        case (ar_state_r)
            ST_RUN: begin
                ARGRANT = ar_sel_s;
                if ((|ar_sel_s) && !ARREADY) ar_state_s = ST_WAIT;
                else                         ar_state_s = ST_RUN;
            end
            ST_WAIT: begin
                ARGRANT = ar_latch_r;
                if (ARREADY && (|(ar_latch_r & ARVALID))) ar_state_s = ST_RUN;
                else                                     ar_state_s = ST_WAIT;
            end
            default: begin
                ARGRANT    = '0;
                ar_state_s = ST_RUN;
            end
        endcase
    end

    // AW grant: same scheme; full FIFO suppresses new grants only in RUN.
    always_comb begin
        aw_state_s = aw_state_r;
        AWGRANT    = '0;
        case (aw_state_r)
            ST_RUN: begin
                AWGRANT = aw_sel_s;
                if ((|aw_sel_s) && !AWREADY) aw_state_s = ST_WAIT;
                else                         aw_state_s = ST_RUN;
            end
            ST_WAIT: begin
                AWGRANT = aw_latch_r;
                if (AWREADY && (|(aw_latch_r & AWVALID))) aw_state_s = ST_RUN;
                else                                     aw_state_s = ST_WAIT;
            end
            default: begin
                AWGRANT    = '0;
                aw_state_s = ST_RUN;
            end
        endcase
    end

    // FSM state and grant latches; the latch samples every RUN cycle and matters only on entry to WAIT.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ar_state_r <= ST_RUN;
            aw_state_r <= ST_RUN;
            ar_latch_r <= '0;
            aw_latch_r <= '0;
        end else begin
            ar_state_r <= ar_state_s;
            aw_state_r <= aw_state_s;
            if (ar_state_r == ST_RUN) ar_latch_r <= ar_sel_s;
            if (aw_state_r == ST_RUN) aw_latch_r <= aw_sel_s;
        end
    end

    assign WGRANT    = fifo_empty_s ? '0 : onehot_f(fifo_mem_r[rd_ptr_r]);
    assign w_pop_s   = WREADY & (|(WGRANT & WVALID & WLAST));
    assign WFIFO_CNT = cnt_r;

    // AW-order FIFO: push granted index on AW handshake, pop on the last W beat.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < WFIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else begin
            if (aw_hs_s) begin
                fifo_mem_r[wr_ptr_r] <= enc_f(AWGRANT);
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (w_pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({aw_hs_s, w_pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_arbiter_mtos_aw_ar.sv
// Bench for axi_arbiter_mtos_aw_ar: vector table, hand-written corner sequences and a random run
// against a queue-based reference model. Honours AXI_ARB_MTOS_RR_EN like the design.
module tb_axi_arbiter_mtos_aw_ar;

    localparam int NUM   = 2;
    localparam int N     = NUM + 1;
    localparam int DEPTH = 4;

    logic         ARESETn, ACLK;
    logic [NUM:0] AWSELECT, AWVALID, AWGRANT, WVALID, WLAST, WGRANT;
    logic [NUM:0] ARSELECT, ARVALID, ARGRANT;
    logic         AWREADY, WREADY, ARREADY;
    logic [2:0]   WFIFO_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    axi_arbiter_mtos_aw_ar #(.NUM(NUM), .WFIFO_DEPTH(DEPTH)) dut (
        .ARESETn(ARESETn), .ACLK(ACLK),
        .AWSELECT(AWSELECT), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWGRANT(AWGRANT),
        .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY), .WGRANT(WGRANT),
        .ARSELECT(ARSELECT), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARGRANT(ARGRANT),
        .WFIFO_CNT(WFIFO_CNT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [2:0] arsel, arvalid;
        logic       arready;
        logic [2:0] awsel, awvalid;
        logic       awready;
        logic [2:0] wvalid, wlast;
        logic       wready;
        logic [2:0] e_ar, e_aw, e_w, e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] arsel, arvalid, input logic arready,
                                input logic [2:0] awsel, awvalid, input logic awready,
                                input logic [2:0] wvalid, wlast, input logic wready,
                                input logic [2:0] e_ar, e_aw, e_w, e_cnt);
        vec_t v;
        v.arsel = arsel;   v.arvalid = arvalid; v.arready = arready;
        v.awsel = awsel;   v.awvalid = awvalid; v.awready = awready;
        v.wvalid = wvalid; v.wlast = wlast;     v.wready = wready;
        v.e_ar = e_ar;     v.e_aw = e_aw;       v.e_w = e_w;     v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_ar, e_aw, e_w, e_cnt);
        check({tag, ".ARGRANT"}, ARGRANT, e_ar);
        check({tag, ".AWGRANT"}, AWGRANT, e_aw);
        check({tag, ".WGRANT"}, WGRANT, e_w);
        check({tag, ".WFIFO_CNT"}, WFIFO_CNT, e_cnt);
    endtask

    task automatic drive(input logic [2:0] arsel, arvalid, input logic arready,
                         input logic [2:0] awsel, awvalid, input logic awready,
                         input logic [2:0] wvalid, wlast, input logic wready);
        ARSELECT = arsel;  ARVALID = arvalid; ARREADY = arready;
        AWSELECT = awsel;  AWVALID = awvalid; AWREADY = awready;
        WVALID   = wvalid; WLAST   = wlast;   WREADY  = wready;
    endtask

    task automatic idle();
        drive(3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        idle();
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // Reference model: FIFO as a queue of master numbers, holds/pointers as plain ints (-1 = none).
    int q[$];
    int m_ar_hold, m_aw_hold, m_ar_ptr, m_aw_ptr;

    function automatic logic has_bit(input logic [2:0] v, input int m);
        return ((v >> m) & 3'b001) != 3'b000;
    endfunction

    function automatic logic [2:0] oh(input int m);
        logic [2:0] one;
        one = 3'b001;
        return (m < 0) ? 3'b000 : (one << m);
    endfunction

    // Fixed priority is modelled as round-robin whose pointer never leaves NUM.
    function automatic int m_sel(input logic [2:0] req, input int start);
        for (int k = 1; k <= N; k++) begin
            if (has_bit(req, (start + k) % N)) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ar_hold = -1;
        m_aw_hold = -1;
        m_ar_ptr  = NUM;
        m_aw_ptr  = NUM;
    endtask

    task automatic model_cycle(input int cyc);
        int  ear, eaw, ew;
        logic ar_hs, aw_hs, w_pop;
        string tag;
        ear = (m_ar_hold >= 0) ? m_ar_hold : m_sel(ARSELECT & ARVALID, m_ar_ptr);
        eaw = (m_aw_hold >= 0) ? m_aw_hold :
              ((q.size() == DEPTH) ? -1 : m_sel(AWSELECT & AWVALID, m_aw_ptr));
        ew  = (q.size() == 0) ? -1 : q[0];
        tag = $sformatf("rand%0d", cyc);
        check_all(tag, oh(ear), oh(eaw), oh(ew), 3'(q.size()));
        ar_hs = (ear >= 0) && has_bit(ARVALID, ear) && ARREADY;
        aw_hs = (eaw >= 0) && has_bit(AWVALID, eaw) && AWREADY;
        w_pop = (ew >= 0) && has_bit(WVALID, ew) && has_bit(WLAST, ew) && WREADY;
        m_ar_hold = ar_hs ? -1 : ear;
        m_aw_hold = aw_hs ? -1 : eaw;
`ifdef AXI_ARB_MTOS_RR_EN
        if (ar_hs) m_ar_ptr = ear;
        if (aw_hs) m_aw_ptr = eaw;
`endif
        if (w_pop) void'(q.pop_front());
        if (aw_hs) q.push_back(eaw);
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn = 1'b0;
        idle();
        #1;
        // During reset: W side cleared, AW/AR grants follow live requests.
        drive(3'b010, 3'b010, 1'b0, 3'b100, 3'b100, 1'b0, 3'b001, 3'b001, 1'b1);
        #1;
        check_all("reset", 3'b010, 3'b100, 3'b000, 3'b000);
        do_reset();

        // AR single/hold, W ordering, early W, AW hold, unselected AW.
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b010,3'b010,1'b1, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b010,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b100,3'b100,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b100,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b100,3'b100,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b100,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b100,3'b100,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b100,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b101,3'b101,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b100,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b101,3'b101,1'b1, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b100,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b001,3'b001,1'b1, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b001,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b100,3'b100,1'b1, 3'b000,3'b000,1'b0, 3'b000,3'b100,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b001,3'b001,1'b1, 3'b000,3'b000,1'b0, 3'b000,3'b001,3'b100,3'd1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b101,3'b000,1'b1, 3'b000,3'b000,3'b100,3'd2));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b101,3'b100,1'b1, 3'b000,3'b000,3'b100,3'd2));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b101,3'b000,1'b1, 3'b000,3'b000,3'b001,3'd1));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b101,3'b001,1'b1, 3'b000,3'b000,3'b001,3'd1));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b010,3'b010,1'b1, 3'b000,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b010,3'b010,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b010,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b011,3'b011,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b010,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b011,3'b011,1'b1, 3'b000,3'b000,1'b0, 3'b000,3'b010,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,3'b010,3'd1));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b010,3'b010,1'b0, 3'b000,3'b000,3'b010,3'd1));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b010,3'b010,1'b1, 3'b000,3'b000,3'b010,3'd1));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,1'b0, 3'b000,3'b000,3'b000,3'd0));
        vecs.push_back(mk(3'b000,3'b000,1'b0, 3'b000,3'b001,1'b1, 3'b000,3'b000,1'b0, 3'b000,3'b000,3'b000,3'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].arsel, vecs[i].arvalid, vecs[i].arready, vecs[i].awsel, vecs[i].awvalid,
                  vecs[i].awready, vecs[i].wvalid, vecs[i].wlast, vecs[i].wready);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_aw, vecs[i].e_w, vecs[i].e_cnt);
            @(negedge ACLK);
        end

        // All three masters hammer AR with ARREADY high.
`ifdef AXI_ARB_MTOS_RR_EN
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
            #1;
            check($sformatf("prio%0d.ARGRANT", c), ARGRANT, rr_exp[c]);
            @(negedge ACLK);
        end

        // Fill the FIFO, observe AW blocking, then release one entry.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(3'b000, 3'b000, 1'b0, 3'b010, 3'b010, 1'b1, 3'b000, 3'b000, 1'b0);
            #1;
            check($sformatf("fill%0d.AWGRANT", c), AWGRANT, 3'b010);
            check($sformatf("fill%0d.WFIFO_CNT", c), WFIFO_CNT, 3'(c));
            @(negedge ACLK);
        end
        #1;
        check_all("full", 3'b000, 3'b000, 3'b010, 3'd4);
        @(negedge ACLK);
        drive(3'b000, 3'b000, 1'b0, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 1'b1);
        #1;
        check_all("full_pop", 3'b000, 3'b000, 3'b010, 3'd4);
        @(negedge ACLK);
        #1;
        check_all("push_pop", 3'b000, 3'b010, 3'b010, 3'd3);
        @(negedge ACLK);
        idle();
        #1;
        check_all("after_pp", 3'b000, 3'b000, 3'b010, 3'd3);
        @(negedge ACLK);

        // Reset while both channels wait and two bursts are queued.
        do_reset();
        drive(3'b000, 3'b000, 1'b0, 3'b100, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0);
        @(negedge ACLK);
        drive(3'b000, 3'b000, 1'b0, 3'b001, 3'b001, 1'b1, 3'b000, 3'b000, 1'b0);
        @(negedge ACLK);
        drive(3'b100, 3'b100, 1'b0, 3'b010, 3'b010, 1'b0, 3'b000, 3'b000, 1'b0);
        #1;
        check_all("pre_rst0", 3'b100, 3'b010, 3'b100, 3'd2);
        @(negedge ACLK);
        drive(3'b001, 3'b001, 1'b0, 3'b100, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0);
        #1;
        check_all("pre_rst1", 3'b100, 3'b010, 3'b100, 3'd2);
        #1;
        ARESETn = 1'b0;
        #1;
        check_all("mid_rst", 3'b001, 3'b100, 3'b000, 3'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        drive(3'b010, 3'b010, 1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        #1;
        check_all("post_rst", 3'b010, 3'b000, 3'b000, 3'd0);
        @(negedge ACLK);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0));
            #1;
            model_cycle(c);
            @(negedge ACLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
